// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input, and decode handshake.
// The master side is the fetch stage; the slave side is memory/decode/branch resolution.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_fault,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_fault,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues single-beat imem reads and hands words to decode.
// Redirects win over the decode handshake; wrong-path responses are dropped via kill_q.
module instruction_fetch #(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter int unsigned PcStep  = 4
) (
  input logic               clock,
  input logic               reset,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam logic [31:0] PcInc = 32'(PcStep);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [6:0]  opcode_q;
  logic        fetch_fault_q;

  logic redirect_misaligned;
  logic req_outstanding;

  assign redirect_misaligned = |bus.redirect_pc[1:0];
  // A request that is still open after this edge cannot be retracted.
  assign req_outstanding     = imem_req_q & ~bus.imem_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= ResetPc;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= ResetPc;
      instr_valid_q <= 1'b0;
      instr_q       <= Nop;
      instr_pc_q    <= 32'h0;
      opcode_q      <= Nop[6:0];
      fetch_fault_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q <= bus.redirect_pc;
      if (redirect_misaligned) begin
        state_q       <= StFault;
        kill_q        <= 1'b0;
        imem_req_q    <= req_outstanding;
        instr_valid_q <= 1'b1;
        fetch_fault_q <= 1'b1;
        instr_q       <= Nop;
        opcode_q      <= Nop[6:0];
        instr_pc_q    <= bus.redirect_pc;
      end else begin
        state_q       <= StReq;
        instr_valid_q <= 1'b0;
        fetch_fault_q <= 1'b0;
        if (req_outstanding) begin
          kill_q <= 1'b1;
        end else begin
          kill_q      <= 1'b0;
          imem_req_q  <= 1'b1;
          imem_addr_q <= bus.redirect_pc;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q     <= StReq;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end
        StReq: begin
          if (bus.imem_ack) begin
            if (kill_q) begin
              kill_q      <= 1'b0;
              imem_addr_q <= pc_q;
            end else begin
              state_q       <= StHold;
              imem_req_q    <= 1'b0;
              instr_valid_q <= 1'b1;
              fetch_fault_q <= 1'b0;
              instr_q       <= bus.imem_rdata;
              opcode_q      <= bus.imem_rdata[6:0];
              instr_pc_q    <= pc_q;
              pc_q          <= pc_q + PcInc;
            end
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            state_q       <= StReq;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            imem_addr_q   <= pc_q;
          end
        end
        StFault: begin
          // Drain a request left open by the faulting redirect.
          if (bus.imem_ack) imem_req_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: hand-computed expectations for reset, handshake,
// stall, redirect/kill, misaligned fault, PC wrap and reset mid-request.
module tb_instruction_fetch;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .ResetPc (32'h0000_0000),
    .PcStep  (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
    #1;
    check_eq("rst_req",    32'(bus.imem_req),    32'h0);
    check_eq("rst_addr",   bus.imem_addr,        32'h0);
    check_eq("rst_valid",  32'(bus.instr_valid), 32'h0);
    check_eq("rst_instr",  bus.instr,            32'h0000_0013);
    check_eq("rst_pc",     bus.instr_pc,         32'h0);
    check_eq("rst_opcode", 32'(bus.opcode),      32'h13);
    check_eq("rst_fault",  32'(bus.fetch_fault), 32'h0);
    step();
    step();
    reset = 1'b0;

    // 1: first fetch, ack one cycle after the request appears
    step();
    check_eq("t1_req",  32'(bus.imem_req), 32'h1);
    check_eq("t1_addr", bus.imem_addr,     32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    step();
    bus.imem_ack = 1'b0;
    check_eq("t1_valid",  32'(bus.instr_valid), 32'h1);
    check_eq("t1_instr",  bus.instr,            32'h0050_0093);
    check_eq("t1_pc",     bus.instr_pc,         32'h0);
    check_eq("t1_opcode", 32'(bus.opcode),      32'h13);
    check_eq("t1_noreq",  32'(bus.imem_req),    32'h0);

    // 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t2_valid", 32'(bus.instr_valid), 32'h1);
      check_eq("t2_instr", bus.instr,            32'h0050_0093);
      check_eq("t2_pc",    bus.instr_pc,         32'h0);
      check_eq("t2_noreq", 32'(bus.imem_req),    32'h0);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check_eq("t2_valid_drop", 32'(bus.instr_valid), 32'h0);
    check_eq("t2_req",        32'(bus.imem_req),    32'h1);
    check_eq("t2_addr",       bus.imem_addr,        32'h4);

    // 3: redirect while the request at 4 is pending; stale word dropped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t3_req_held",  32'(bus.imem_req), 32'h1);
    check_eq("t3_addr_held", bus.imem_addr,     32'h4);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    check_eq("t3_stale_invalid", 32'(bus.instr_valid), 32'h0);
    check_eq("t3_req",           32'(bus.imem_req),    32'h1);
    check_eq("t3_addr",          bus.imem_addr,        32'h100);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00A0_0113;
    step();
    bus.imem_ack = 1'b0;
    check_eq("t3_valid", 32'(bus.instr_valid), 32'h1);
    check_eq("t3_instr", bus.instr,            32'h00A0_0113);
    check_eq("t3_pc",    bus.instr_pc,         32'h100);

    // 4: redirect coincides with the handshake; redirect wins
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step();
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    check_eq("t4_valid_drop", 32'(bus.instr_valid), 32'h0);
    check_eq("t4_addr",       bus.imem_addr,        32'h200);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0033;
    step();
    bus.imem_ack = 1'b0;
    check_eq("t4_pc",     bus.instr_pc,    32'h200);
    check_eq("t4_opcode", 32'(bus.opcode), 32'h33);

    // 5: misaligned redirect raises a fault with no memory traffic
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t5_fault", 32'(bus.fetch_fault), 32'h1);
    check_eq("t5_valid", 32'(bus.instr_valid), 32'h1);
    check_eq("t5_pc",    bus.instr_pc,         32'h102);
    check_eq("t5_instr", bus.instr,            32'h0000_0013);
    check_eq("t5_noreq", 32'(bus.imem_req),    32'h0);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_hold_fault", 32'(bus.fetch_fault), 32'h1);
      check_eq("t5_hold_noreq", 32'(bus.imem_req),    32'h0);
    end
    bus.instr_ready = 1'b0;

    // 6: PC wraps from FFFF_FFFC to 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t6_fault_clr", 32'(bus.fetch_fault), 32'h0);
    check_eq("t6_req",       32'(bus.imem_req),    32'h1);
    check_eq("t6_addr0",     bus.imem_addr,        32'hFFFF_FFFC);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0010_0073;
    step();
    bus.imem_ack = 1'b0;
    check_eq("t6_pc", bus.instr_pc, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check_eq("t6_addr1", bus.imem_addr,     32'h0);
    check_eq("t6_req1",  32'(bus.imem_req), 32'h1);

    // Reset mid-request drops imem_req at once; a late ack in idle is ignored
    reset = 1'b1;
    #1;
    check_eq("rst_mid_req", 32'(bus.imem_req), 32'h0);
    step();
    reset          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ack = 1'b0;
    check_eq("late_ack_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("late_ack_req",   32'(bus.imem_req),    32'h1);
    check_eq("late_ack_addr",  bus.imem_addr,        32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
